ex_hazard_controller: RTL

//  Hazard and forwarding controller for the 16-bit, 8-register pipelined datapath around the execute stage.

---
 rtl/ex_hazard_controller_pkg.sv | 40 ++++
 rtl/ex_hazard_controller_if.sv | 41 ++++
 rtl/ex_hazard_controller_forward_select.sv | 43 ++++
 rtl/ex_hazard_controller.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ex_hazard_controller_pkg.sv
// Shared types and constants for the execute-stage hazard/forwarding controller.
package ex_hazard_controller_pkg;

    // Operand forwarding select encodings
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    // Architectural register that may be hardwired to zero
    localparam logic [2:0] REG_ZERO = 3'd0;

    typedef logic [2:0] reg_id_t;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // One shadow scoreboard entry per in-flight stage
    typedef struct packed {
        logic    valid;
        reg_id_t dest;
        logic    reg_write;
        logic    mem_read;
    } shadow_t;

    // Source registers of the instruction currently in EX
    typedef struct packed {
        reg_id_t rs;
        reg_id_t rt;
    } srcs_t;

    // True when r is the zero register and R0 is hardwired
    function automatic logic is_zero_reg(input reg_id_t r, input logic hw);
        return hw && (r == REG_ZERO);
    endfunction

endpackage

// File: rtl/ex_hazard_controller_if.sv
// Control bus between the pipelined datapath and the hazard controller.
// master = datapath side, slave = controller side.
interface ex_hazard_controller_if;
    import ex_hazard_controller_pkg::*;

    // ID / EX stage information from the datapath
    logic       id_valid;
    reg_id_t    id_rs;
    reg_id_t    id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    reg_id_t    id_dest;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       ex_branch;
    logic       ex_zero;

    // Pipeline control back to the datapath
    logic       pc_write_en;
    logic       if_id_write_en;
    logic       id_ex_bubble;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_reg_write, id_mem_read, ex_branch, ex_zero,
        input  pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush,
               id_ex_flush, fwd_a_sel, fwd_b_sel
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_reg_write, id_mem_read, ex_branch, ex_zero,
        output pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush,
               id_ex_flush, fwd_a_sel, fwd_b_sel
    );

endinterface

// File: rtl/ex_hazard_controller_forward_select.sv
// Per-operand forwarding select: compares one EX source register against
// the MEM and WB shadow entries. The younger (MEM) producer wins; a load
// sitting in MEM has no data yet, so it never forwards from EX/MEM.
module ex_hazard_controller_forward_select
    import ex_hazard_controller_pkg::*;
#(
    parameter int ZERO_REG_HW = 1
) (
    input  reg_id_t    i_src,
    input  shadow_t    i_mem,
    input  shadow_t    i_wb,
    output logic [1:0] o_sel
);

    localparam logic ZERO_HW = (ZERO_REG_HW != 0);

    logic w_src_zero;
    logic w_mem_hit;
    logic w_wb_hit;
    logic w_unused_wb_mem_read;

    assign w_unused_wb_mem_read = i_wb.mem_read;

    // Match detection against each older producer
    always_comb begin
        w_src_zero = is_zero_reg(i_src, ZERO_HW);
        w_mem_hit  = i_mem.valid && i_mem.reg_write && !i_mem.mem_read &&
                     (i_mem.dest == i_src) && !w_src_zero;
        w_wb_hit   = i_wb.valid && i_wb.reg_write &&
                     (i_wb.dest == i_src) && !w_src_zero;
    end

    // Priority encode: EX/MEM over MEM/WB over register file
    always_comb begin
        o_sel = FWD_REGFILE;
        if (w_mem_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ex_hazard_controller.sv
// Hazard and forwarding controller around the execute stage of a 16-bit,
// 8-register pipeline. Tracks in-flight destinations in a shadow scoreboard
// (EX, MEM, WB), inserts load-use bubbles, squashes IF/ID and ID/EX on a
// taken branch, and selects ALU operand forwarding paths.
module ex_hazard_controller
    import ex_hazard_controller_pkg::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int ZERO_REG_HW  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    ex_hazard_controller_if.slave  bus
);

    localparam logic       ZERO_HW  = (ZERO_REG_HW != 0);
    localparam logic [1:0] CNT_INIT = 2'(LOAD_LATENCY - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;

    shadow_t    r_ex;
    shadow_t    r_mem;
    shadow_t    r_wb;
    srcs_t      r_ex_src;

    logic       w_taken;
    logic       w_load_use;
    logic       w_rs_hit;
    logic       w_rt_hit;
    logic       w_stall;
    logic       w_flush;

    // Hazard detection from registered EX shadow plus current ID/EX inputs
    always_comb begin
        w_rs_hit   = bus.id_uses_rs && (bus.id_rs == r_ex.dest);
        w_rt_hit   = bus.id_uses_rt && (bus.id_rt == r_ex.dest);
        w_load_use = (r_state == ST_RUN) && bus.id_valid && r_ex.valid &&
                     r_ex.mem_read && !is_zero_reg(r_ex.dest, ZERO_HW) &&
                     (w_rs_hit || w_rt_hit);
        w_taken    = bus.ex_branch && bus.ex_zero && r_ex.valid;
    end

    // Next-state and stall/flush decisions; a taken branch overrides any stall
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        if (w_taken) begin
            w_flush     = 1'b1;
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = 2'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_load_use) begin
                        w_stall = 1'b1;
                        if (LOAD_LATENCY > 1) begin
                            w_state_nxt = ST_STALL;
                            w_cnt_nxt   = CNT_INIT;
                        end
                    end
                end
                ST_STALL: begin
                    w_stall = 1'b1;
                    if (r_cnt <= 2'd1) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = 2'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                end
                ST_FLUSH: begin
                    // Instruction in ID was squashed; detection stays masked
                    w_state_nxt = ST_RUN;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    // FSM state and stall counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Shadow scoreboard: EX takes ID (or a bubble), MEM and WB always advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            if (w_stall || w_flush) begin
                r_ex <= '0;
            end else begin
                r_ex <= {bus.id_valid, bus.id_dest, bus.id_reg_write, bus.id_mem_read};
            end
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    // Source ids of the instruction entering EX; only meaningful when EX is valid
    always_ff @(posedge clk) begin
        r_ex_src <= {bus.id_rs, bus.id_rt};
    end

    ex_hazard_controller_forward_select #(
        .ZERO_REG_HW (ZERO_REG_HW)
    ) u_fwd_a (
        .i_src (r_ex_src.rs),
        .i_mem (r_mem),
        .i_wb  (r_wb),
        .o_sel (bus.fwd_a_sel)
    );

    ex_hazard_controller_forward_select #(
        .ZERO_REG_HW (ZERO_REG_HW)
    ) u_fwd_b (
        .i_src (r_ex_src.rt),
        .i_mem (r_mem),
        .i_wb  (r_wb),
        .o_sel (bus.fwd_b_sel)
    );

    assign bus.pc_write_en    = !w_stall;
    assign bus.if_id_write_en = !w_stall;
    assign bus.id_ex_bubble   = w_stall;
    assign bus.if_id_flush    = w_flush;
    assign bus.id_ex_flush    = w_flush;

endmodule
